// File: rtl/pcseq_pkg.sv
// Shared types for the program-counter sequencer.
// PCSEQ_ISIZE may be overridden by a global define of the same name.
`ifndef PCSEQ_ISIZE
`define PCSEQ_ISIZE 16
`endif

package pcseq_pkg;

  localparam int PCSEQ_ISIZE_DEF = `PCSEQ_ISIZE;

  localparam int FCW = 3;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_BR   = 2'd1,
    SRC_JMP  = 2'd2,
    SRC_TRAP = 2'd3
  } src_t;

endpackage

// File: rtl/pcseq_flush_ctr.sv
// Loadable 3-bit down-counter timing the post-redirect bubble.
// Load wins over decrement; decrement saturates at zero.
module pcseq_flush_ctr
  import pcseq_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_load,
  input  logic [FCW-1:0] i_load_val,
  input  logic           i_dec,
  output logic           o_zero
);

  logic [FCW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - FCW'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: increment, stall, redirect, halt, flush bubbles.
// Optional trap support (TRAP_VEC redirect, epc_o) under PCSEQ_TRAP_EN.
module pc_sequencer
  import pcseq_pkg::*;
#(
  parameter int               ISIZE        = PCSEQ_ISIZE_DEF,
  parameter logic [ISIZE-1:0] RESET_VEC    = '0,
  parameter int               FLUSH_CYCLES = 2,
  parameter logic [ISIZE-1:0] TRAP_VEC     = ISIZE'(16'h0010)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             br_taken_i,
  input  logic [ISIZE-1:0] br_target_i,
  input  logic             jmp_i,
  input  logic [ISIZE-1:0] jmp_target_i,
  input  logic             halt_i,
  input  logic             resume_i,
  input  logic             trap_i,
`ifdef PCSEQ_TRAP_EN
  output logic [ISIZE-1:0] epc_o,
`endif
  output logic [ISIZE-1:0] pc_o,
  output logic             fetch_valid_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic [1:0]       state_o
);

  state_t           r_state;
  logic [ISIZE-1:0] r_pc;
  logic             r_fv;
  logic             r_flush;
  logic             r_halted;

  src_t             w_src;
  logic [ISIZE-1:0] w_target;
  logic             w_redir;
  logic             w_trap;
  logic             w_rf;
  logic             w_ctr_zero;

  assign w_rf = (r_state == ST_RUN) || (r_state == ST_FLUSH);

`ifdef PCSEQ_TRAP_EN
  assign w_trap = trap_i && (r_state != ST_BOOT);
`else
  logic w_unused;
  assign w_trap   = 1'b0;
  assign w_unused = ^{trap_i, TRAP_VEC};
`endif

  // Trap > branch > jump; branch/jump only count in RUN and FLUSH
  always_comb begin
    w_src    = SRC_NONE;
    w_target = r_pc;
    if (w_trap) begin
      w_src    = SRC_TRAP;
      w_target = TRAP_VEC;
    end else if (w_rf && br_taken_i) begin
      w_src    = SRC_BR;
      w_target = br_target_i;
    end else if (w_rf && jmp_i) begin
      w_src    = SRC_JMP;
      w_target = jmp_target_i;
    end
  end

  assign w_redir = (w_src != SRC_NONE);

  pcseq_flush_ctr u_ctr (
    .clk        (clk),
    .rst_n      (rst),
    .i_load     (w_redir),
    .i_load_val (FCW'(FLUSH_CYCLES - 1)),
    .i_dec      (r_state == ST_FLUSH),
    .o_zero     (w_ctr_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_BOOT;
      r_pc     <= RESET_VEC;
      r_fv     <= 1'b0;
      r_flush  <= 1'b0;
      r_halted <= 1'b0;
    end else if (w_redir) begin
      r_state  <= ST_FLUSH;
      r_pc     <= w_target;
      r_fv     <= 1'b0;
      r_flush  <= 1'b1;
      r_halted <= 1'b0;
    end else begin
      unique case (r_state)
        ST_BOOT: begin
          r_state <= ST_RUN;
          r_fv    <= 1'b1;
        end
        ST_RUN: begin
          if (halt_i) begin
            r_state  <= ST_HALT;
            r_fv     <= 1'b0;
            r_halted <= 1'b1;
          end else if (!stall_i) begin
            r_pc <= r_pc + ISIZE'(1);
          end
        end
        ST_FLUSH: begin
          if (w_ctr_zero) begin
            r_state <= ST_RUN;
            r_fv    <= 1'b1;
            r_flush <= 1'b0;
          end
        end
        ST_HALT: begin
          if (resume_i) begin
            r_state  <= ST_RUN;
            r_fv     <= 1'b1;
            r_halted <= 1'b0;
          end
        end
        default: r_state <= ST_BOOT;
      endcase
    end
  end

`ifdef PCSEQ_TRAP_EN
  logic [ISIZE-1:0] r_epc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_epc <= '0;
    end else if (w_src == SRC_TRAP) begin
      r_epc <= r_pc;
    end
  end

  assign epc_o = r_epc;
`endif

  assign pc_o          = r_pc;
  assign fetch_valid_o = r_fv;
  assign flush_o       = r_flush;
  assign halted_o      = r_halted;
  assign state_o       = r_state;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: boot, branch/jump, halt, wrap, reset.
// Trap scenarios run when PCSEQ_TRAP_EN is defined.
module tb_pc_sequencer;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        br_taken_i;
  logic [15:0] br_target_i;
  logic        jmp_i;
  logic [15:0] jmp_target_i;
  logic        halt_i;
  logic        resume_i;
  logic        trap_i;
  logic [15:0] pc_o;
  logic        fetch_valid_o;
  logic        flush_o;
  logic        halted_o;
  logic [1:0]  state_o;
`ifdef PCSEQ_TRAP_EN
  logic [15:0] epc_o;
`endif

  int n_pass = 0;
  int n_tot  = 0;

  pc_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .br_taken_i    (br_taken_i),
    .br_target_i   (br_target_i),
    .jmp_i         (jmp_i),
    .jmp_target_i  (jmp_target_i),
    .halt_i        (halt_i),
    .resume_i      (resume_i),
    .trap_i        (trap_i),
`ifdef PCSEQ_TRAP_EN
    .epc_o         (epc_o),
`endif
    .pc_o          (pc_o),
    .fetch_valid_o (fetch_valid_o),
    .flush_o       (flush_o),
    .halted_o      (halted_o),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    stall_i      = 1'b0;
    br_taken_i   = 1'b0;
    br_target_i  = '0;
    jmp_i        = 1'b0;
    jmp_target_i = '0;
    halt_i       = 1'b0;
    resume_i     = 1'b0;
    trap_i       = 1'b0;
  endtask

  // Leaves the DUT in RUN with pc_o == tgt at a negedge.
  task automatic jump_to(input logic [15:0] tgt);
    jmp_i = 1'b1; jmp_target_i = tgt;
    @(negedge clk);
    jmp_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_tot++; if (pc_o !== 16'h0000) $display("FAIL rst_pc act=%h exp=0000", pc_o); else n_pass++;
    n_tot++; if (fetch_valid_o !== 1'b0) $display("FAIL rst_fv act=%b exp=0", fetch_valid_o); else n_pass++;
    n_tot++; if (flush_o !== 1'b0) $display("FAIL rst_flush act=%b exp=0", flush_o); else n_pass++;
    n_tot++; if (halted_o !== 1'b0) $display("FAIL rst_halted act=%b exp=0", halted_o); else n_pass++;
    n_tot++; if (state_o !== 2'd0) $display("FAIL rst_state act=%0d exp=0", state_o); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_tot++; if (state_o !== 2'd0) $display("FAIL boot_state act=%0d exp=0", state_o); else n_pass++;
    n_tot++; if (fetch_valid_o !== 1'b0) $display("FAIL boot_fv act=%b exp=0", fetch_valid_o); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tot++; if (pc_o !== 16'(i)) $display("FAIL run_pc%0d act=%h exp=%h", i, pc_o, 16'(i)); else n_pass++;
      n_tot++; if (fetch_valid_o !== 1'b1) $display("FAIL run_fv%0d act=%b exp=1", i, fetch_valid_o); else n_pass++;
      n_tot++; if (state_o !== 2'd1) $display("FAIL run_st%0d act=%0d exp=1", i, state_o); else n_pass++;
    end
  endtask

  task automatic test_branch();
    @(negedge clk);
    @(negedge clk);
    n_tot++; if (pc_o !== 16'h0005) $display("FAIL br_pre act=%h exp=0005", pc_o); else n_pass++;
    br_taken_i = 1'b1; br_target_i = 16'h0040;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      br_taken_i = 1'b0;
      n_tot++; if (flush_o !== 1'b1) $display("FAIL br_flush%0d act=%b exp=1", i, flush_o); else n_pass++;
      n_tot++; if (fetch_valid_o !== 1'b0) $display("FAIL br_fv%0d act=%b exp=0", i, fetch_valid_o); else n_pass++;
      n_tot++; if (state_o !== 2'd2) $display("FAIL br_st%0d act=%0d exp=2", i, state_o); else n_pass++;
    end
    @(negedge clk);
    n_tot++; if (pc_o !== 16'h0040) $display("FAIL br_tgt act=%h exp=0040", pc_o); else n_pass++;
    n_tot++; if (fetch_valid_o !== 1'b1) $display("FAIL br_fv_run act=%b exp=1", fetch_valid_o); else n_pass++;
    n_tot++; if (flush_o !== 1'b0) $display("FAIL br_flush_off act=%b exp=0", flush_o); else n_pass++;
    @(negedge clk);
    n_tot++; if (pc_o !== 16'h0041) $display("FAIL br_next act=%h exp=0041", pc_o); else n_pass++;
  endtask

  task automatic test_priority();
    br_taken_i = 1'b1; br_target_i = 16'h0020;
    jmp_i = 1'b1; jmp_target_i = 16'h0030;
    stall_i = 1'b1;
    @(negedge clk);
    clear_inputs();
    n_tot++; if (pc_o !== 16'h0020) $display("FAIL prio_pc act=%h exp=0020", pc_o); else n_pass++;
    n_tot++; if (state_o !== 2'd2) $display("FAIL prio_st act=%0d exp=2", state_o); else n_pass++;
    jmp_i = 1'b1; jmp_target_i = 16'h0050;
    @(negedge clk);
    clear_inputs();
    n_tot++; if (pc_o !== 16'h0050) $display("FAIL reflush_pc act=%h exp=0050", pc_o); else n_pass++;
    n_tot++; if (flush_o !== 1'b1) $display("FAIL reflush_f act=%b exp=1", flush_o); else n_pass++;
    @(negedge clk);
    n_tot++; if (state_o !== 2'd2) $display("FAIL reload_st act=%0d exp=2", state_o); else n_pass++;
    halt_i = 1'b1; stall_i = 1'b1;
    @(negedge clk);
    clear_inputs();
    n_tot++; if (state_o !== 2'd1) $display("FAIL flush_ign_st act=%0d exp=1", state_o); else n_pass++;
    n_tot++; if (halted_o !== 1'b0) $display("FAIL flush_ign_h act=%b exp=0", halted_o); else n_pass++;
    n_tot++; if (pc_o !== 16'h0050) $display("FAIL flush_ign_pc act=%h exp=0050", pc_o); else n_pass++;
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_tot++; if (pc_o !== 16'h0050) $display("FAIL stall_pc act=%h exp=0050", pc_o); else n_pass++;
    end
    stall_i = 1'b0;
    @(negedge clk);
    n_tot++; if (pc_o !== 16'h0051) $display("FAIL stall_rel act=%h exp=0051", pc_o); else n_pass++;
  endtask

  task automatic test_halt();
    jump_to(16'h0009);
    n_tot++; if (pc_o !== 16'h0009) $display("FAIL halt_pre act=%h exp=0009", pc_o); else n_pass++;
    halt_i = 1'b1;
    @(negedge clk);
    halt_i = 1'b0;
    n_tot++; if (state_o !== 2'd3) $display("FAIL halt_st act=%0d exp=3", state_o); else n_pass++;
    n_tot++; if (fetch_valid_o !== 1'b0) $display("FAIL halt_fv act=%b exp=0", fetch_valid_o); else n_pass++;
    br_taken_i = 1'b1; br_target_i = 16'h0077;
    jmp_i = 1'b1; jmp_target_i = 16'h0088;
    stall_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tot++; if (pc_o !== 16'h0009) $display("FAIL halt_pc%0d act=%h exp=0009", i, pc_o); else n_pass++;
      n_tot++; if (halted_o !== 1'b1) $display("FAIL halt_h%0d act=%b exp=1", i, halted_o); else n_pass++;
    end
    clear_inputs();
    resume_i = 1'b1;
    @(negedge clk);
    resume_i = 1'b0;
    n_tot++; if (state_o !== 2'd1) $display("FAIL resume_st act=%0d exp=1", state_o); else n_pass++;
    n_tot++; if (halted_o !== 1'b0) $display("FAIL resume_h act=%b exp=0", halted_o); else n_pass++;
    n_tot++; if (fetch_valid_o !== 1'b1) $display("FAIL resume_fv act=%b exp=1", fetch_valid_o); else n_pass++;
    n_tot++; if (pc_o !== 16'h0009) $display("FAIL resume_pc act=%h exp=0009", pc_o); else n_pass++;
    @(negedge clk);
    n_tot++; if (pc_o !== 16'h000A) $display("FAIL resume_next act=%h exp=000a", pc_o); else n_pass++;
  endtask

  task automatic test_wrap();
    jump_to(16'hFFFF);
    n_tot++; if (pc_o !== 16'hFFFF) $display("FAIL wrap_pre act=%h exp=ffff", pc_o); else n_pass++;
    @(negedge clk);
    n_tot++; if (pc_o !== 16'h0000) $display("FAIL wrap_pc act=%h exp=0000", pc_o); else n_pass++;
    n_tot++; if (fetch_valid_o !== 1'b1) $display("FAIL wrap_fv act=%b exp=1", fetch_valid_o); else n_pass++;
  endtask

  task automatic test_reset_mid_flush();
    br_taken_i = 1'b1; br_target_i = 16'h0033;
    @(negedge clk);
    clear_inputs();
    n_tot++; if (flush_o !== 1'b1) $display("FAIL mf_pre act=%b exp=1", flush_o); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_tot++; if (pc_o !== 16'h0000) $display("FAIL mf_pc act=%h exp=0000", pc_o); else n_pass++;
    n_tot++; if (flush_o !== 1'b0) $display("FAIL mf_flush act=%b exp=0", flush_o); else n_pass++;
    n_tot++; if (fetch_valid_o !== 1'b0) $display("FAIL mf_fv act=%b exp=0", fetch_valid_o); else n_pass++;
    n_tot++; if (state_o !== 2'd0) $display("FAIL mf_st act=%0d exp=0", state_o); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_tot++; if (state_o !== 2'd1) $display("FAIL mf_rel_st act=%0d exp=1", state_o); else n_pass++;
    n_tot++; if (pc_o !== 16'h0000) $display("FAIL mf_rel_pc act=%h exp=0000", pc_o); else n_pass++;
  endtask

`ifdef PCSEQ_TRAP_EN
  task automatic test_trap();
    jump_to(16'h0022);
    trap_i = 1'b1;
    @(negedge clk);
    trap_i = 1'b0;
    n_tot++; if (epc_o !== 16'h0022) $display("FAIL trap_epc act=%h exp=0022", epc_o); else n_pass++;
    n_tot++; if (pc_o !== 16'h0010) $display("FAIL trap_pc act=%h exp=0010", pc_o); else n_pass++;
    n_tot++; if (flush_o !== 1'b1) $display("FAIL trap_flush act=%b exp=1", flush_o); else n_pass++;
    repeat (2) @(negedge clk);
    n_tot++; if (fetch_valid_o !== 1'b1) $display("FAIL trap_fv act=%b exp=1", fetch_valid_o); else n_pass++;
    n_tot++; if (pc_o !== 16'h0010) $display("FAIL trap_run act=%h exp=0010", pc_o); else n_pass++;
  endtask
`else
  task automatic test_trap();
    n_tot++; if (pc_o !== 16'h0001) $display("FAIL trap_pre act=%h exp=0001", pc_o); else n_pass++;
    trap_i = 1'b1;
    @(negedge clk);
    trap_i = 1'b0;
    n_tot++; if (pc_o !== 16'h0002) $display("FAIL trap_ign_pc act=%h exp=0002", pc_o); else n_pass++;
    n_tot++; if (flush_o !== 1'b0) $display("FAIL trap_ign_f act=%b exp=0", flush_o); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_branch();
    test_priority();
    test_stall();
    test_halt();
    test_wrap();
    test_reset_mid_flush();
    @(negedge clk);
    test_trap();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
